mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DATA_W, default 32, width of the bus, MDR and memory data.
REQ-002 Parameter ADDR_W, default 9, width of the MAR and memory address.
REQ-003 Parameter TIMEOUT, default 15, maximum number of wait cycles before an access aborts (1..255).
REQ-004 Clock  in  1  single clock; all state changes on the rising edge.
REQ-005 Clear  in  1  reset; asynchronous, active-high.
REQ-006 bus_in  in  DATA_W  value currently on the datapath bus.
REQ-007 MAR_In  in  1  load the MAR from bus_in[ADDR_W-1:0].
REQ-008 MDR_In  in  1  load the MDR from bus_in.
REQ-009 Read  in  1  start a memory read at the MAR address.
REQ-010 Write  in  1  start a memory write of the MDR to the MAR address.
REQ-011 mdr_out  out  DATA_W  MDR contents, driven to the bus mux.
REQ-012 busy  out  1  high while the state is RD or WR.
REQ-013 done  out  1  one-cycle pulse when an access completes successfully.
REQ-014 err  out  1  one-cycle pulse when an access times out.
REQ-015 mem_addr  out  ADDR_W  memory address; always equals the MAR.
REQ-016 mem_wdata  out  DATA_W  memory write data; always equals the MDR.
REQ-017 mem_rd / mem_wr  out  1 each  memory request strobes; registered outputs.
REQ-018 mem_rdata  in  DATA_W  memory read data.
REQ-019 mem_ready  in  1  memory completion; mem_rdata is valid in the same cycle.

Function
REQ-020 FSM states: IDLE, RD, WR, DONE, ERR.
REQ-021 IDLE: Read=1 -> RD; else Write=1 -> WR; Read and Write together -> RD (read has priority, write is dropped).
REQ-022 RD: mem_rd=1; on mem_ready=1, the MDR loads mem_rdata and the state goes to DONE.
REQ-023 WR: mem_wr=1; on mem_ready=1, the state goes to DONE.
REQ-024 DONE: done=1 for exactly one cycle, then IDLE.
REQ-025 ERR: err=1 for exactly one cycle, then IDLE; the MDR is unchanged.
REQ-026 MAR_In and MDR_In take effect only in IDLE; they are ignored in every other state.
REQ-027 If MAR_In or MDR_In is asserted on the same edge as Read or Write, the access uses the newly loaded value.
REQ-028 Read and Write outside IDLE are ignored; they are not queued.
REQ-029 Minimum latency is 2 cycles from the Read/Write edge to done, with mem_ready high in the first RD/WR cycle.
REQ-030 The wait counter clears on entry to RD/WR and increments each cycle mem_ready=0.
REQ-031 When the wait counter reaches TIMEOUT with mem_ready=0 -> ERR.
REQ-032 mem_ready in the same cycle as the counter reaching TIMEOUT counts as success.
REQ-033 mem_ready in IDLE, DONE or ERR is ignored.

Reset
REQ-034 Clear=1 forces, asynchronously: state=IDLE; MAR=0; MDR=0; counter=0; mem_rd=mem_wr=busy=done=err=0.
REQ-035 Clear asserted mid-access abandons the access with no done or err pulse; the MDR reads 0 after reset.

Configuration
REQ-036 Macro MAU_TIMEOUT_EN defined: the timeout counter and ERR state exist as specified in REQ-030 to REQ-032.
REQ-037 MAU_TIMEOUT_EN undefined: no counter; RD/WR wait indefinitely for mem_ready; err is tied to 0.

Structure
REQ-038 Package mau_pkg holds the state enum and the default DATA_W, ADDR_W and TIMEOUT constants.
REQ-039 Sub-module mau_timer (parameter TIMEOUT; inputs clr and en; output expired) implements the wait counter and is instantiated only under MAU_TIMEOUT_EN.

Verification
REQ-040 bus_in=0x5 with MAR_In, then Read; memory returns 0xDEADBEEF with ready after 3 waits -> mem_addr=5, MDR=0xDEADBEEF, done 1 pulse, busy 4 cycles.
REQ-041 Same edge: MAR_In (bus_in=0x1F), MDR_In, and Write with mem_ready tied high -> one mem_wr cycle at address 0x1F, data=bus_in, done 2 cycles after the Write edge.
REQ-042 Read and Write on the same edge -> only mem_rd asserts and mem_wr stays 0.
REQ-043 TIMEOUT=15 with mem_ready never asserted -> err pulses after 15 wait cycles and MDR keeps its prior value. Repeat with ready in the 15th cycle -> done, no err.
REQ-044 Clear pulsed in cycle 2 of a read -> all outputs 0 immediately, no done, state IDLE; a subsequent read works.
REQ-045 MDR_In asserted while busy with bus_in=0x1234 -> MDR is unaffected.

Source files
------------

// File: rtl/mau_pkg.sv
// mau_pkg: shared state encoding and default sizes for the memory access unit.
package mau_pkg;
    localparam int MAU_DATA_W  = 32;
    localparam int MAU_ADDR_W  = 9;
    localparam int MAU_TIMEOUT = 15;
    typedef enum logic [2:0] {IDLE, RD, WR, DONE, ERR} mau_state_e;
endpackage

// File: rtl/mau_if.sv
// mau_if: datapath-side controls plus memory request/response signals of the access unit.
interface mau_if import mau_pkg::*; #(
    parameter int DATA_W = MAU_DATA_W,
    parameter int ADDR_W = MAU_ADDR_W
);
    logic [DATA_W-1:0] bus_in, mdr_out, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic MAR_In, MDR_In, Read, Write, busy, done, err, mem_rd, mem_wr, mem_ready;
    modport master (
        output bus_in, MAR_In, MDR_In, Read, Write, mem_rdata, mem_ready,
        input  mdr_out, busy, done, err, mem_addr, mem_wdata, mem_rd, mem_wr
    );
    modport slave (
        input  bus_in, MAR_In, MDR_In, Read, Write, mem_rdata, mem_ready,
        output mdr_out, busy, done, err, mem_addr, mem_wdata, mem_rd, mem_wr
    );
endinterface

// File: rtl/mau_timer.sv
// mau_timer: counts memory wait cycles; expired flags the wait that reaches TIMEOUT.
module mau_timer import mau_pkg::*; #(
    parameter int TIMEOUT = MAU_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [7:0] cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= cnt + 8'd1;
    // the current wait is the TIMEOUT-th one when TIMEOUT-1 waits are already counted
    assign expired = en && cnt == 8'(TIMEOUT - 1);
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MAR/MDR memory access sequencer; define MAU_TIMEOUT_EN for the wait timeout and ERR path.
module mem_access_unit import mau_pkg::*; #(
    parameter int DATA_W  = MAU_DATA_W,
    parameter int ADDR_W  = MAU_ADDR_W,
    parameter int TIMEOUT = MAU_TIMEOUT
) (
    input logic  Clock,
    input logic  Clear,
    mau_if.slave bus
);
    mau_state_e state, next;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic rd_q, wr_q, idle, busy, expired;
    assign idle = state == IDLE;
    assign busy = state == RD || state == WR;
`ifdef MAU_TIMEOUT_EN
    mau_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk(Clock), .rst(Clear), .clr(!busy), .en(busy && !bus.mem_ready), .expired(expired)
    );
    assign bus.err = state == ERR;
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT);
    assign expired = 1'b0;
    assign bus.err = 1'b0;
`endif
    // read wins when Read and Write arrive together; ready beats a simultaneous expiry
    always_comb begin
        next = state;
        next = idle ? (bus.Read ? RD : bus.Write ? WR : IDLE)
             : busy ? (bus.mem_ready ? DONE : expired ? ERR : state)
             : IDLE;
    end
    always_ff @(posedge Clock or posedge Clear)
        if (Clear) begin
            state <= IDLE;
            mar   <= '0;
            mdr   <= '0;
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
        end else begin
            state <= next;
            rd_q  <= next == RD;
            wr_q  <= next == WR;
            if (idle && bus.MAR_In) mar <= bus.bus_in[ADDR_W-1:0];
            if (idle && bus.MDR_In) mdr <= bus.bus_in;
            else if (state == RD && bus.mem_ready) mdr <= bus.mem_rdata;
        end
    assign bus.busy      = busy;
    assign bus.done      = state == DONE;
    assign bus.mdr_out   = mdr;
    assign bus.mem_addr  = mar;
    assign bus.mem_wdata = mdr;
    assign bus.mem_rd    = rd_q;
    assign bus.mem_wr    = wr_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of the memory access unit; timeout steps depend on MAU_TIMEOUT_EN.
module tb_mem_access_unit;
    logic Clock = 1'b0;
    logic Clear = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    int busy_cyc, done_cyc;
    logic err_seen, drop_seen;
    mau_if bus ();
    mem_access_unit dut (.Clock(Clock), .Clear(Clear), .bus(bus));
    always #5 Clock = ~Clock;
    task automatic tick;
        @(posedge Clock);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    initial begin
        bus.bus_in = '0; bus.MAR_In = 0; bus.MDR_In = 0; bus.Read = 0; bus.Write = 0;
        bus.mem_rdata = '0; bus.mem_ready = 0;
        tick; tick;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_rd", bus.mem_rd, 0);
        chk("rst_wr", bus.mem_wr, 0);
        chk("rst_mdr", bus.mdr_out, 0);
        chk("rst_addr", bus.mem_addr, 0);
        Clear = 0;
        tick;
        // read with three wait cycles
        bus.bus_in = 32'h5; bus.MAR_In = 1;
        tick;
        bus.MAR_In = 0;
        chk("mar_load", bus.mem_addr, 9'h5);
        chk("idle_busy", bus.busy, 0);
        bus.Read = 1;
        tick;
        bus.Read = 0;
        chk("rd_strobe", bus.mem_rd, 1);
        chk("rd_no_wr", bus.mem_wr, 0);
        busy_cyc = 0;
        for (int i = 0; i < 3; i++) begin
            busy_cyc += int'(bus.busy);
            tick;
        end
        bus.mem_ready = 1; bus.mem_rdata = 32'hDEADBEEF;
        busy_cyc += int'(bus.busy);
        tick;
        bus.mem_ready = 0;
        chk("rd_done", bus.done, 1);
        chk("rd_mdr", bus.mdr_out, 32'hDEADBEEF);
        chk("rd_rd_off", bus.mem_rd, 0);
        chk("rd_busy_cycles", busy_cyc, 4);
        tick;
        chk("rd_done_pulse", bus.done, 0);
        // MAR, MDR and Write on one edge, ready tied high
        bus.bus_in = 32'h1F; bus.MAR_In = 1; bus.MDR_In = 1; bus.Write = 1; bus.mem_ready = 1;
        tick;
        bus.MAR_In = 0; bus.MDR_In = 0; bus.Write = 0;
        chk("wr_strobe", bus.mem_wr, 1);
        chk("wr_addr", bus.mem_addr, 9'h1F);
        chk("wr_data", bus.mem_wdata, 32'h1F);
        chk("wr_not_done_yet", bus.done, 0);
        tick;
        chk("wr_done", bus.done, 1);
        chk("wr_strobe_off", bus.mem_wr, 0);
        tick;
        chk("ready_in_idle_busy", bus.busy, 0);
        chk("ready_in_idle_done", bus.done, 0);
        bus.mem_ready = 0;
        // Read and Write together: read wins
        bus.Read = 1; bus.Write = 1;
        tick;
        bus.Read = 0; bus.Write = 0;
        chk("both_rd", bus.mem_rd, 1);
        chk("both_wr", bus.mem_wr, 0);
        bus.mem_ready = 1; bus.mem_rdata = 32'hCAFE0001;
        tick;
        bus.mem_ready = 0;
        chk("both_done", bus.done, 1);
        chk("both_mdr", bus.mdr_out, 32'hCAFE0001);
        tick;
        // MAR/MDR loads and new requests ignored while busy
        bus.Read = 1;
        tick;
        bus.Read = 0;
        bus.bus_in = 32'h1234; bus.MAR_In = 1; bus.MDR_In = 1; bus.Write = 1;
        tick;
        bus.MAR_In = 0; bus.MDR_In = 0;
        chk("busy_mdr_hold", bus.mdr_out, 32'hCAFE0001);
        chk("busy_mar_hold", bus.mem_addr, 9'h1F);
        chk("busy_no_wr", bus.mem_wr, 0);
        bus.Write = 0;
        bus.mem_ready = 1; bus.mem_rdata = 32'h11112222;
        tick;
        bus.mem_ready = 0;
        chk("busy_rd_done", bus.done, 1);
        chk("busy_rd_mdr", bus.mdr_out, 32'h11112222);
        bus.Write = 1;
        tick;
        bus.Write = 0;
        tick;
        chk("no_queue_busy", bus.busy, 0);
        chk("no_queue_wr", bus.mem_wr, 0);
`ifdef MAU_TIMEOUT_EN
        // no ready: err after 15 waits, MDR kept
        bus.Read = 1;
        tick;
        bus.Read = 0;
        err_seen = 0; drop_seen = 0;
        for (int i = 0; i < 14; i++) begin
            tick;
            err_seen |= bus.err;
            drop_seen |= !bus.busy;
        end
        chk("to_no_early_err", err_seen, 0);
        chk("to_still_busy", drop_seen, 0);
        tick;
        chk("to_err", bus.err, 1);
        chk("to_not_done", bus.done, 0);
        chk("to_busy_off", bus.busy, 0);
        chk("to_mdr_kept", bus.mdr_out, 32'h11112222);
        tick;
        chk("to_err_pulse", bus.err, 0);
        // ready in the 15th cycle still succeeds
        bus.Read = 1;
        tick;
        bus.Read = 0;
        for (int i = 0; i < 14; i++) tick;
        bus.mem_ready = 1; bus.mem_rdata = 32'h0F0F0F0F;
        tick;
        bus.mem_ready = 0;
        chk("late_done", bus.done, 1);
        chk("late_no_err", bus.err, 0);
        chk("late_mdr", bus.mdr_out, 32'h0F0F0F0F);
        tick;
`else
        // no timeout: waits indefinitely
        bus.Read = 1;
        tick;
        bus.Read = 0;
        err_seen = 0; drop_seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick;
            err_seen |= bus.err;
            drop_seen |= !bus.busy;
        end
        chk("nto_no_err", err_seen, 0);
        chk("nto_still_busy", drop_seen, 0);
        bus.mem_ready = 1; bus.mem_rdata = 32'h0F0F0F0F;
        tick;
        bus.mem_ready = 0;
        chk("nto_done", bus.done, 1);
        chk("nto_mdr", bus.mdr_out, 32'h0F0F0F0F);
        tick;
`endif
        // asynchronous clear in cycle 2 of a read
        bus.Read = 1;
        tick;
        bus.Read = 0;
        tick;
        #1 Clear = 1;
        #1;
        chk("clr_busy", bus.busy, 0);
        chk("clr_rd", bus.mem_rd, 0);
        chk("clr_mdr", bus.mdr_out, 0);
        chk("clr_addr", bus.mem_addr, 0);
        chk("clr_done", bus.done, 0);
        chk("clr_err", bus.err, 0);
        #1 Clear = 0;
        done_cyc = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            done_cyc += int'(bus.done) + int'(bus.err) + int'(bus.busy);
        end
        chk("clr_quiet", done_cyc, 0);
        bus.bus_in = 32'h3; bus.MAR_In = 1; bus.Read = 1; bus.mem_ready = 1; bus.mem_rdata = 32'hABCD;
        tick;
        bus.MAR_In = 0; bus.Read = 0;
        chk("post_clr_addr", bus.mem_addr, 9'h3);
        chk("post_clr_rd", bus.mem_rd, 1);
        tick;
        bus.mem_ready = 0;
        chk("post_clr_done", bus.done, 1);
        chk("post_clr_mdr", bus.mdr_out, 32'hABCD);
        tick;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
